// File: rtl/pc_gen.sv
// pc_gen: IF1 program counter with prioritised redirects, stall capture
// and an optional return-address stack enabled by the PC_RAS_EN macro.
module pc_gen #(
    parameter int unsigned        XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_VECTOR = XLEN'(32'hFFFF_F000),
    parameter int unsigned        PC_INC       = 4,
    parameter int unsigned        RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_pc,
    input  logic            call_valid,
    input  logic [XLEN-1:0] call_ret_addr,
    input  logic            ret_valid,
    output logic [XLEN-1:0] pc_if1,
    output logic [XLEN-1:0] next_pc_if1,
    output logic            ras_pred
);

    logic [XLEN-1:0] pc_q;
    logic            pend_v_q;
    logic            pend_trap_q;
    logic [XLEN-1:0] pend_tgt_q;

    logic            eff_v;
    logic            eff_trap;
    logic [XLEN-1:0] eff_tgt;

    logic            ras_hit;
    logic [XLEN-1:0] ras_top;

    logic [XLEN-1:0] trap_a;
    logic [XLEN-1:0] br_a;
    logic [XLEN-1:0] call_a;

    assign trap_a = {trap_pc[XLEN-1:2], 2'b00};
    assign br_a   = {br_pc[XLEN-1:2], 2'b00};
    assign call_a = {call_ret_addr[XLEN-1:2], 2'b00};

    // Pick the winning redirect: new trap, pending trap, new branch, pending branch
    always_comb begin
        eff_v    = 1'b0;
        eff_trap = 1'b0;
        eff_tgt  = '0;
        if (trap_valid) begin
            eff_v    = 1'b1;
            eff_trap = 1'b1;
            eff_tgt  = trap_a;
        end else if (pend_v_q && pend_trap_q) begin
            eff_v    = 1'b1;
            eff_trap = 1'b1;
            eff_tgt  = pend_tgt_q;
        end else if (br_valid) begin
            eff_v    = 1'b1;
            eff_tgt  = br_a;
        end else if (pend_v_q) begin
            eff_v    = 1'b1;
            eff_tgt  = pend_tgt_q;
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   top_q;
    logic [PW-1:0]   top_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            ras_we;
    logic [PW-1:0]   ras_wa;
    logic            ras_upd;
    logic            nonempty;

    assign ras_upd  = en & ~eff_v;
    assign nonempty = (cnt_q != '0);
    assign ras_hit  = ras_upd & ret_valid & nonempty;
    assign ras_top  = ras_q[top_q];

    // Next RAS pointer/count and write slot for push, pop or push+pop
    always_comb begin
        top_d  = top_q;
        cnt_d  = cnt_q;
        ras_we = 1'b0;
        ras_wa = top_q;
        if (en && eff_v && eff_trap) begin
            cnt_d = '0;
        end else if (ras_upd) begin
            if (call_valid && ret_valid) begin
                ras_we = 1'b1;
                if (!nonempty) begin
                    cnt_d = CW'(1);
                end
            end else if (call_valid) begin
                top_d  = top_q + PW'(1);
                ras_wa = top_q + PW'(1);
                ras_we = 1'b1;
                if (cnt_q != CW'(RAS_DEPTH)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (ret_valid && nonempty) begin
                top_d = top_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // RAS pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // RAS storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[ras_wa] <= call_a;
        end
    end
`else
    logic unused_ras;
    assign unused_ras = ^{call_valid, ret_valid, call_a};
    assign ras_hit    = 1'b0;
    assign ras_top    = '0;
`endif

    logic unused_lsb;
    assign unused_lsb = ^{trap_pc[1:0], br_pc[1:0], call_ret_addr[1:0]};

    // Next fetch address: hold on stall, else redirect, RAS or sequential
    always_comb begin
        next_pc_if1 = pc_q;
        ras_pred    = 1'b0;
        if (en) begin
            if (eff_v) begin
                next_pc_if1 = eff_tgt;
            end else if (ras_hit) begin
                next_pc_if1 = ras_top;
                ras_pred    = 1'b1;
            end else begin
                next_pc_if1 = pc_q + XLEN'(PC_INC);
            end
        end
    end

    // Fetch PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else if (en) begin
            pc_q <= next_pc_if1;
        end
    end

    // Capture redirects during stalls; consumed on the next advance
    always_ff @(posedge clk) begin
        if (reset || en) begin
            pend_v_q    <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_tgt_q  <= '0;
        end else begin
            pend_v_q    <= eff_v;
            pend_trap_q <= eff_trap;
            pend_tgt_q  <= eff_tgt;
        end
    end

    assign pc_if1 = pc_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and random stimulus for pc_gen against a
// queue-based reference model of the fetch PC and return stack.
module tb_pc_gen;
    localparam logic [31:0] RV    = 32'h8000_0000;
    localparam int          DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, trap_valid, br_valid, call_valid, ret_valid;
    logic [31:0] trap_pc, br_pc, call_ret_addr;
    logic [31:0] pc_if1, next_pc_if1;
    logic        ras_pred;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    bit          m_pv, m_pt;
    logic [31:0] m_ptgt;
    logic [31:0] m_ras[$];

    logic [31:0] obs_next;
    logic        obs_pred;

    pc_gen #(
        .XLEN(32), .RESET_VECTOR(RV), .PC_INC(4), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .br_valid(br_valid), .br_pc(br_pc),
        .call_valid(call_valid), .call_ret_addr(call_ret_addr),
        .ret_valid(ret_valid),
        .pc_if1(pc_if1), .next_pc_if1(next_pc_if1), .ras_pred(ras_pred)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 0; en = 1; trap_valid = 0; br_valid = 0;
        call_valid = 0; ret_valid = 0;
        trap_pc = 0; br_pc = 0; call_ret_addr = 0;
    endtask

    // One clock: check comb outputs before the edge, pc after it
    task automatic cycle();
        bit          ev, et, ep;
        logic [31:0] etg, en_pc, ca;
        #2;
        ev = 0; et = 0; etg = 0;
        if (trap_valid) begin
            ev = 1; et = 1; etg = trap_pc & ~32'h3;
        end else if (m_pv && m_pt) begin
            ev = 1; et = 1; etg = m_ptgt;
        end else if (br_valid) begin
            ev = 1; etg = br_pc & ~32'h3;
        end else if (m_pv) begin
            ev = 1; etg = m_ptgt;
        end
        ca = call_ret_addr & ~32'h3;
        ep = en && !ev && ret_valid && RAS_ON && (m_ras.size() > 0);
        if (!en)      en_pc = m_pc;
        else if (ev)  en_pc = etg;
        else if (ep)  en_pc = m_ras[m_ras.size()-1];
        else          en_pc = m_pc + 32'd4;
        obs_next = next_pc_if1;
        obs_pred = ras_pred;
        if (!reset) begin
            chk("next_pc", next_pc_if1, en_pc);
            chk("ras_pred", {31'b0, ras_pred}, {31'b0, ep});
        end
        @(posedge clk);
        #1;
        if (reset) begin
            m_pc = RV; m_pv = 0; m_pt = 0; m_ptgt = 0;
            m_ras.delete();
        end else if (en) begin
            m_pc = en_pc;
            m_pv = 0;
            if (ev && et) begin
                m_ras.delete();
            end else if (!ev && RAS_ON) begin
                if (call_valid && ret_valid) begin
                    if (m_ras.size() > 0) m_ras[m_ras.size()-1] = ca;
                    else m_ras.push_back(ca);
                end else if (call_valid) begin
                    m_ras.push_back(ca);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end else if (ret_valid && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
        end else begin
            m_pv = ev; m_pt = et; m_ptgt = etg;
        end
        chk("pc_if1", pc_if1, m_pc);
    endtask

    initial begin
        m_pc = 0; m_pv = 0; m_pt = 0; m_ptgt = 0;
        idle();
        reset = 1;
        #1;
        cycle();
        cycle();
        chk("rst_pc", pc_if1, RV);
        reset = 0;
        cycle();
        chk("seq4", pc_if1, RV + 32'd4);
        cycle();
        chk("seq8", pc_if1, RV + 32'd8);
        reset = 1;
        cycle();
        chk("mid_rst", pc_if1, RV);
        reset = 0;

        trap_valid = 1; trap_pc = 32'h8000_0103;
        br_valid = 1; br_pc = 32'h8000_0200;
        cycle();
        chk("trap_pri", pc_if1, 32'h8000_0100);
        idle();

        en = 0; br_valid = 1; br_pc = 32'h8000_0040;
        cycle();
        br_valid = 0;
        cycle();
        trap_valid = 1; trap_pc = 32'h8000_0080;
        cycle();
        trap_valid = 0;
        cycle();
        cycle();
        en = 1;
        cycle();
        chk("stall_trap", pc_if1, 32'h8000_0080);
        chk("stall_next", obs_next, 32'h8000_0080);
        br_valid = 1; br_pc = 32'h8000_0300;
        en = 0;
        cycle();
        br_valid = 1; br_pc = 32'h8000_0400;
        cycle();
        idle();
        cycle();
        chk("br_repl", pc_if1, 32'h8000_0400);

        for (int i = 1; i <= 5; i++) begin
            call_valid = 1; call_ret_addr = 32'(i * 16);
            cycle();
        end
        call_valid = 0; ret_valid = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
`ifdef PC_RAS_EN
            if (i < 4) chk("ras_pop", obs_next, 32'(80 - i * 16));
`endif
        end
        chk("ras_empty", {31'b0, obs_pred}, 32'd0);
        idle();
        call_valid = 1; call_ret_addr = 32'h10;
        cycle();
        call_ret_addr = 32'h20;
        cycle();
        call_ret_addr = 32'h70; ret_valid = 1;
        cycle();
`ifdef PC_RAS_EN
        chk("pp_pred", obs_next, 32'h20);
`endif
        call_valid = 0;
        cycle();
`ifdef PC_RAS_EN
        chk("pp_after", obs_next, 32'h70);
`endif
        idle();
        call_valid = 1; call_ret_addr = 32'h90;
        cycle();
        idle();
        trap_valid = 1; trap_pc = 32'h8000_1000;
        cycle();
        idle();
        ret_valid = 1;
        cycle();
        chk("trap_clr", {31'b0, obs_pred}, 32'd0);
        idle();

        trap_valid = 1; trap_pc = 32'hFFFF_FFFE;
        cycle();
        idle();
        cycle();
        chk("wrap", pc_if1, 32'h0);

        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(99) < 2);
            en            = ($urandom_range(99) < 75);
            trap_valid    = ($urandom_range(99) < 5);
            br_valid      = ($urandom_range(99) < 12);
            call_valid    = ($urandom_range(99) < 25);
            ret_valid     = ($urandom_range(99) < 25);
            trap_pc       = $urandom;
            br_pc         = $urandom;
            call_ret_addr = $urandom;
            cycle();
        end
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
